// File: rtl/mem_line_pkg.sv
// Shared types and helpers for the main_memory line controller.
package mem_line_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    localparam int unsigned LINE_WORDS_DEF = 4;

    function automatic int unsigned off_width(input int unsigned line_words);
        return (line_words > 1) ? $clog2(line_words) : 1;
    endfunction

    // Next slot within a line; wraps without carrying into the line base.
    function automatic int unsigned slot_sel(input int unsigned start,
                                             input int unsigned step,
                                             input int unsigned line_words);
        return (start + step) & (line_words - 1);
    endfunction

endpackage

// File: rtl/mem_line_buf.sv
// LINE_WORDS x DWIDTH line register file: per-slot write, parallel load, flat readout, async clear.
module mem_line_buf #(
    parameter int unsigned DWIDTH     = 32,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned OFF_W      = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_wr_en,
    input  logic [OFF_W-1:0]             i_wr_idx,
    input  logic [DWIDTH-1:0]            i_wr_data,
    input  logic                         i_load,
    input  logic [LINE_WORDS*DWIDTH-1:0] i_load_data,
    output logic [LINE_WORDS*DWIDTH-1:0] o_rdata
);

    logic [DWIDTH-1:0] r_slot [LINE_WORDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LINE_WORDS; i++) r_slot[i] <= '0;
        end else if (i_load) begin
            for (int unsigned i = 0; i < LINE_WORDS; i++)
                r_slot[i] <= i_load_data[i*DWIDTH +: DWIDTH];
        end else if (i_wr_en) begin
            r_slot[i_wr_idx] <= i_wr_data;
        end
    end

    for (genvar g = 0; g < LINE_WORDS; g++) begin : g_rd
        assign o_rdata[g*DWIDTH +: DWIDTH] = r_slot[g];
    end

endmodule

// File: rtl/mem_line_ctrl.sv
// Line controller: whole-line fills/writebacks sequenced as one-word-per-cycle main_memory accesses.
// Define MEM_LINE_CRIT_WORD_EN for critical-word-first fills and the bus_crit_* early-word outputs.
module mem_line_ctrl
    import mem_line_pkg::*;
#(
    parameter int unsigned  AWIDTH     = 9,
    parameter int unsigned  DWIDTH     = 32,
    parameter int unsigned  LINE_WORDS = LINE_WORDS_DEF,
    localparam int unsigned OFF_W      = off_width(LINE_WORDS)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         bus_req,
    input  logic                         bus_we,
    input  logic [AWIDTH-1:0]            bus_addr,
    input  logic [LINE_WORDS*DWIDTH-1:0] bus_wdata,
    output logic                         bus_busy,
    output logic                         bus_done,
    output logic [LINE_WORDS*DWIDTH-1:0] bus_rdata,
    output logic                         mem_rd,
    output logic                         mem_wr,
    output logic [AWIDTH-1:0]            mem_addr,
    output logic [DWIDTH-1:0]            mem_wdata,
    input  logic [DWIDTH-1:0]            mem_rdata,
    input  logic                         mem_ready
`ifdef MEM_LINE_CRIT_WORD_EN
    ,
    output logic                         bus_crit_valid,
    output logic [DWIDTH-1:0]            bus_crit_data
`endif
);

    state_t                    r_state;
    logic                      r_we;
    logic [AWIDTH-OFF_W-1:0]   r_base;
    logic [OFF_W-1:0]          r_off;
    logic [OFF_W-1:0]          r_cnt;
    logic                      r_cap_pend;
    logic [OFF_W-1:0]          r_cap_off;
    logic                      r_mem_rd;
    logic                      r_mem_wr;
    logic                      r_done;
    logic [OFF_W-1:0]          w_start_off;
    logic                      w_wload;
    logic [LINE_WORDS*DWIDTH-1:0] w_wline;
    logic [DWIDTH-1:0]         w_wword [LINE_WORDS];
    logic                      w_unused_ok;
`ifdef MEM_LINE_CRIT_WORD_EN
    logic                      r_crit_valid;

    assign w_start_off = bus_we ? '0 : bus_addr[OFF_W-1:0];
`else
    assign w_start_off = '0;
`endif

    assign w_unused_ok = ^{bus_addr[OFF_W-1:0], mem_ready};
    assign w_wload     = (r_state == ST_IDLE) && bus_req && bus_we;

    // Read data lags its access by one cycle, so the slot to fill is the previous offset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            r_base     <= '0;
            r_off      <= '0;
            r_cnt      <= '0;
            r_cap_pend <= 1'b0;
            r_cap_off  <= '0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_done     <= 1'b0;
`ifdef MEM_LINE_CRIT_WORD_EN
            r_crit_valid <= 1'b0;
`endif
        end else begin
            r_done     <= 1'b0;
            r_cap_pend <= 1'b0;
`ifdef MEM_LINE_CRIT_WORD_EN
            r_crit_valid <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (bus_req) begin
                        r_we     <= bus_we;
                        r_base   <= bus_addr[AWIDTH-1:OFF_W];
                        r_off    <= w_start_off;
                        r_cnt    <= '0;
                        r_mem_rd <= ~bus_we;
                        r_mem_wr <= bus_we;
                        r_state  <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_off      <= OFF_W'(slot_sel(32'(r_off), 1, LINE_WORDS));
                    r_cnt      <= r_cnt + 1'b1;
                    r_cap_pend <= ~r_we;
                    r_cap_off  <= r_off;
`ifdef MEM_LINE_CRIT_WORD_EN
                    r_crit_valid <= ~r_we && (r_cnt == '0);
`endif
                    if (r_cnt == OFF_W'(LINE_WORDS - 1)) begin
                        r_mem_rd <= 1'b0;
                        r_mem_wr <= 1'b0;
                        if (r_we) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    mem_line_buf #(.DWIDTH(DWIDTH), .LINE_WORDS(LINE_WORDS), .OFF_W(OFF_W)) u_wbuf (
        .clk         (clk),
        .rst_n       (reset_n),
        .i_wr_en     (1'b0),
        .i_wr_idx    ('0),
        .i_wr_data   ('0),
        .i_load      (w_wload),
        .i_load_data (bus_wdata),
        .o_rdata     (w_wline)
    );

    mem_line_buf #(.DWIDTH(DWIDTH), .LINE_WORDS(LINE_WORDS), .OFF_W(OFF_W)) u_rbuf (
        .clk         (clk),
        .rst_n       (reset_n),
        .i_wr_en     (r_cap_pend),
        .i_wr_idx    (r_cap_off),
        .i_wr_data   (mem_rdata),
        .i_load      (1'b0),
        .i_load_data ('0),
        .o_rdata     (bus_rdata)
    );

    for (genvar g = 0; g < LINE_WORDS; g++) begin : g_wword
        assign w_wword[g] = w_wline[g*DWIDTH +: DWIDTH];
    end

    assign bus_busy  = (r_state != ST_IDLE);
    assign bus_done  = r_done;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = (r_mem_rd || r_mem_wr) ? {r_base, r_off} : '0;
    assign mem_wdata = r_mem_wr ? w_wword[r_off] : '0;
`ifdef MEM_LINE_CRIT_WORD_EN
    assign bus_crit_valid = r_crit_valid;
    assign bus_crit_data  = r_crit_valid ? mem_rdata : '0;
`endif

    a_rd_wr_excl: assert property (@(posedge clk) disable iff (!reset_n) !(mem_rd && mem_wr));
    a_ready_idle: assert property (@(posedge clk) disable iff (!reset_n) (mem_rd || mem_wr) |-> !mem_ready);

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Directed self-checking bench for mem_line_ctrl with a simple main_memory model.
module tb_mem_line_ctrl;

    logic         clk;
    logic         reset_n;
    logic         bus_req;
    logic         bus_we;
    logic [8:0]   bus_addr;
    logic [127:0] bus_wdata;
    logic         bus_busy;
    logic         bus_done;
    logic [127:0] bus_rdata;
    logic         mem_rd;
    logic         mem_wr;
    logic [8:0]   mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_ready;
`ifdef MEM_LINE_CRIT_WORD_EN
    logic         bus_crit_valid;
    logic [31:0]  bus_crit_data;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0]  mem [512];
    logic [8:0]   lat_addr;

    logic [127:0] la, lb, lc, ld;
    logic [8:0]   ea;
    logic [31:0]  dw;
    logic [1:0]   so;
    logic [15:0]  busy_v, done_v;
    logic [9:0]   acc8;

    mem_line_ctrl #(.AWIDTH(9), .DWIDTH(32), .LINE_WORDS(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_busy  (bus_busy),
        .bus_done  (bus_done),
        .bus_rdata (bus_rdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
`ifdef MEM_LINE_CRIT_WORD_EN
        ,
        .bus_crit_valid (bus_crit_valid),
        .bus_crit_data  (bus_crit_data)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // main_memory: address latched / write committed on negedge, read data registered on posedge.
    always @(negedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) lat_addr <= mem_addr;
    end
    always @(posedge clk) mem_rdata <= mem[lat_addr];

    always @(negedge clk) begin
        if (reset_n) begin
            total++;
            assert ({mem_rd & mem_wr, (mem_rd | mem_wr) & mem_ready} === 2'b00) else begin
                bad++;
                $error("FAIL proto obs rd=%0b wr=%0b ready=%0b exp no overlap", mem_rd, mem_wr, mem_ready);
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        la = 128'hA3333333_A2222222_A1111111_A0000000;
        lb = 128'hB3333333_B2222222_B1111111_B0000000;
        lc = 128'hC3333333_C2222222_C1111111_C0000000;
        ld = 128'hD3333333_D2222222_D1111111_D0000000;
        for (int i = 0; i < 512; i++) mem[i] <= 32'h5000_0000 | i;
        for (int i = 0; i < 4; i++) begin
            mem[9'h040 + i] <= la[i*32 +: 32];
            mem[9'h044 + i] <= lc[i*32 +: 32];
            mem[9'h080 + i] <= lb[i*32 +: 32];
        end
        lat_addr  <= '0;
        reset_n   = 1'b0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        mem_ready = 1'b0;
        step();
        step();
        chk("rst_ctrl", {bus_busy, bus_done, mem_rd, mem_wr, mem_addr}, '0);
        chk("rst_wdata", mem_wdata, '0);
        chk("rst_rdata", bus_rdata, '0);
        reset_n = 1'b1;
        step();

        // Fill of line 0x040
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 9'h040;
        step();
        bus_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ea = 9'h040 + 9'(k);
            chk("fill_acc", {bus_busy, bus_done, mem_rd, mem_wr, mem_addr}, {4'b1010, ea});
            step();
        end
        chk("fill_cap", {bus_busy, bus_done, mem_rd, mem_wr}, 4'b1000);
        step();
        chk("fill_done", {bus_busy, bus_done}, 2'b11);
        chk("fill_data", bus_rdata, la);
        step();
        chk("fill_idle", {bus_busy, bus_done}, 2'b00);

        // Writeback to the top line of memory
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = 9'h1FC; bus_wdata = ld;
        step();
        bus_req = 1'b0; bus_wdata = '0; bus_addr = '0;
        for (int k = 0; k < 4; k++) begin
            ea = 9'h1FC + 9'(k);
            dw = ld[k*32 +: 32];
            chk("wb_acc", {bus_busy, bus_done, mem_rd, mem_wr, mem_addr, mem_wdata}, {4'b1001, ea, dw});
            step();
        end
        chk("wb_done", {bus_busy, bus_done, mem_rd, mem_wr}, 4'b1100);
        chk("wb_rdata_kept", bus_rdata, la);
        step();
        chk("wb_idle", {bus_busy, bus_done}, 2'b00);
        chk("wb_mem", {mem[9'h1FF], mem[9'h1FE], mem[9'h1FD], mem[9'h1FC]}, ld);
        chk("wb_no_spill", {mem[9'h1FB], mem[9'h000]}, {32'h5000_01FB, 32'h5000_0000});

        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 9'h1FC;
        step();
        bus_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ea = 9'h1FC + 9'(k);
            chk("refill_acc", {mem_rd, mem_wr, mem_addr}, {2'b10, ea});
            step();
        end
        step();
        chk("refill_done", {bus_busy, bus_done}, 2'b11);
        chk("refill_data", bus_rdata, ld);
        step();

        // Back-to-back: request held through the first fill, address changed mid-op
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 9'h080;
        step();
        bus_addr = 9'h044;
        busy_v = '0; done_v = '0; acc8 = '0;
        for (int c = 1; c < 15; c++) begin
            busy_v[c] = bus_busy;
            done_v[c] = bus_done;
            if (c == 6) chk("b2b_first_data", bus_rdata, lb);
            if (c == 8) begin
                acc8 = {mem_rd, mem_addr};
                bus_req = 1'b0;
            end
            step();
        end
        chk("b2b_busy", busy_v, 16'h3F7E);
        chk("b2b_done", done_v, 16'h2040);
        chk("b2b_second_acc", acc8, {1'b1, 9'h044});
        chk("b2b_second_data", bus_rdata, lc);

        // Reset in cycle 2 of a fill
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 9'h040;
        step();
        bus_req = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", {bus_busy, bus_done, mem_rd, mem_wr, mem_addr}, '0);
        chk("rst_mid_rdata", bus_rdata, '0);
        step();
        reset_n = 1'b1;
        step();
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 9'h080;
        step();
        bus_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ea = 9'h080 + 9'(k);
            chk("post_rst_acc", {mem_rd, mem_wr, mem_addr}, {2'b10, ea});
            step();
        end
        chk("post_rst_cap", {bus_busy, bus_done}, 2'b10);
        step();
        chk("post_rst_done", {bus_busy, bus_done}, 2'b11);
        chk("post_rst_data", bus_rdata, lb);
        step();

        // Unaligned fill: wraps from the requested word with the feature, else starts at 0
`ifdef MEM_LINE_CRIT_WORD_EN
        so = 2'd2;
`else
        so = 2'd0;
`endif
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 9'h042;
        step();
        bus_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ea = {7'h10, 2'(so + 2'(k))};
            chk("ua_acc", {mem_rd, mem_wr, mem_addr}, {2'b10, ea});
`ifdef MEM_LINE_CRIT_WORD_EN
            if (k == 1) chk("crit_word", {bus_crit_valid, bus_crit_data}, {1'b1, 32'hA2222222});
            else        chk("crit_quiet", {bus_crit_valid, bus_crit_data}, '0);
`endif
            step();
        end
        step();
        chk("ua_done", {bus_busy, bus_done}, 2'b11);
        chk("ua_data", bus_rdata, la);
        step();
        chk("ua_idle", {bus_busy, bus_done}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
